// File: rtl/mult_seq_param.sv
// Sequential shift-and-add multiplier; Done pulses the cycle after edge E0+2*WIDTH (St sampled at E0).
// St is honoured only in IDLE (no queueing); define MULT_SIGNED_EN to add the Sgn two's-complement mode.
module mult_seq_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 Clk,
    input  logic                 reset_n,
    input  logic                 St,
    input  logic [WIDTH-1:0]     Mcand,
    input  logic [WIDTH-1:0]     Mplier,
`ifdef MULT_SIGNED_EN
    input  logic                 Sgn,
`endif
    output logic                 Idle,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product
);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mc_q, mc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     mcand_ld, mplier_ld;
    logic [2*WIDTH:0]     acc_shr;

`ifdef MULT_SIGNED_EN
    logic                 neg_q, neg_d;

    // Magnitudes are loaded; the most-negative value maps onto unsigned 2^(WIDTH-1).
    assign mcand_ld  = (Sgn && Mcand[WIDTH-1])  ? WIDTH'(~Mcand + 1'b1)  : Mcand;
    assign mplier_ld = (Sgn && Mplier[WIDTH-1]) ? WIDTH'(~Mplier + 1'b1) : Mplier;
`else
    assign mcand_ld  = Mcand;
    assign mplier_ld = Mplier;
`endif

    assign acc_shr = acc_q >> 1;
    assign Product = prod_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
`ifdef MULT_SIGNED_EN
        neg_d   = neg_q;
`endif
        Idle    = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                Idle = 1'b1;
                if (St) begin
                    acc_d   = {(WIDTH+1)'(0), mplier_ld};
                    mc_d    = mcand_ld;
                    cnt_d   = '0;
`ifdef MULT_SIGNED_EN
                    neg_d   = Sgn & (Mcand[WIDTH-1] ^ Mplier[WIDTH-1]);
`endif
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                Busy = 1'b1;
                if (acc_q[0])
                    acc_d[2*WIDTH:WIDTH] = acc_q[2*WIDTH:WIDTH] + {1'b0, mc_q};
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                Busy  = 1'b1;
                acc_d = acc_shr;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    // The carry bit has been shifted down, so the low 2*WIDTH bits are the full result.
`ifdef MULT_SIGNED_EN
                    prod_d = neg_q ? (2*WIDTH)'(~acc_shr[2*WIDTH-1:0] + 1'b1) : acc_shr[2*WIDTH-1:0];
`else
                    prod_d = acc_shr[2*WIDTH-1:0];
`endif
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mc_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
`ifdef MULT_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
`ifdef MULT_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

endmodule

// File: tb/tb_mult_seq_param.sv
// Bench for mult_seq_param: WIDTH 8/4/16 instances, scoreboarded products, latency and handshake checks.
module tb_mult_seq_param;

    logic        Clk = 1'b0;
    logic        reset_n;
    logic        st8, st4, st16;
    logic [15:0] mc, mp;
`ifdef MULT_SIGNED_EN
    logic        sgn;
`endif

    logic        idle8, busy8, done8;
    logic [15:0] prod8;
    logic        idle4, busy4, done4;
    logic [7:0]  prod4;
    logic        idle16, busy16, done16;
    logic [31:0] prod16;

    int          sel;
    logic        idle_v, busy_v, done_v;
    logic [31:0] prod_v;

    logic [31:0] sb[$];
    int          total = 0;
    int          passed = 0;
    int          fails = 0;

    always #5 Clk = ~Clk;

    mult_seq_param #(.WIDTH(8)) u_w8 (
        .Clk(Clk), .reset_n(reset_n), .St(st8), .Mcand(mc[7:0]), .Mplier(mp[7:0]),
`ifdef MULT_SIGNED_EN
        .Sgn(sgn),
`endif
        .Idle(idle8), .Busy(busy8), .Done(done8), .Product(prod8)
    );

    mult_seq_param #(.WIDTH(4)) u_w4 (
        .Clk(Clk), .reset_n(reset_n), .St(st4), .Mcand(mc[3:0]), .Mplier(mp[3:0]),
`ifdef MULT_SIGNED_EN
        .Sgn(sgn),
`endif
        .Idle(idle4), .Busy(busy4), .Done(done4), .Product(prod4)
    );

    mult_seq_param #(.WIDTH(16)) u_w16 (
        .Clk(Clk), .reset_n(reset_n), .St(st16), .Mcand(mc), .Mplier(mp),
`ifdef MULT_SIGNED_EN
        .Sgn(sgn),
`endif
        .Idle(idle16), .Busy(busy16), .Done(done16), .Product(prod16)
    );

    always_comb begin
        idle_v = idle8;
        busy_v = busy8;
        done_v = done8;
        prod_v = {16'h0, prod8};
        case (sel)
            1: begin
                idle_v = idle4; busy_v = busy4; done_v = done4; prod_v = {24'h0, prod4};
            end
            2: begin
                idle_v = idle16; busy_v = busy16; done_v = done16; prod_v = prod16;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        if (sb.size() == 0) return 32'hxxxx_xxxx;
        return sb.pop_front();
    endfunction

    // One St pulse, then watch latency, Busy/Idle, Product hold and the scoreboarded result.
    task automatic mul(input int s, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string tag);
        int w, cyc, nbusy, nidle, nchg;
        logic [31:0] held;
        w = (s == 1) ? 4 : (s == 2) ? 16 : 8;
        sel = s;
        @(negedge Clk);
        mc = a;
        mp = b;
        case (s)
            1: st4 = 1'b1;
            2: st16 = 1'b1;
            default: st8 = 1'b1;
        endcase
        sb.push_back(exp);
        held = prod_v;
        @(negedge Clk);
        st8 = 1'b0; st4 = 1'b0; st16 = 1'b0;
        mc = ~a;
        mp = ~b;
        cyc = 1; nbusy = 0; nidle = 0; nchg = 0;
        while (!done_v && cyc < 200) begin
            if (busy_v) nbusy++;
            if (idle_v) nidle++;
            if (prod_v !== held) nchg++;
            @(negedge Clk);
            cyc++;
        end
        chk({tag, "_done"},    32'(done_v), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - 1), 32'(2 * w));
        chk({tag, "_busy"},    32'(nbusy), 32'(2 * w));
        chk({tag, "_idle"},    32'(nidle), 32'd0);
        chk({tag, "_hold"},    32'(nchg), 32'd0);
        chk({tag, "_prod"},    prod_v, pop_exp());
        @(negedge Clk);
        chk({tag, "_pulse"},   32'({done_v, idle_v}), 32'b01);
        chk({tag, "_kept"},    prod_v, exp);
    endtask

    initial begin
        int nd, last;
        reset_n = 1'b0;
        st8 = 1'b0; st4 = 1'b0; st16 = 1'b0;
        mc = '0; mp = '0;
        sel = 0;
`ifdef MULT_SIGNED_EN
        sgn = 1'b0;
`endif
        #3;
        chk("rst_idle", 32'(idle_v), 32'd1);
        chk("rst_busy", 32'(busy_v), 32'd0);
        chk("rst_done", 32'(done_v), 32'd0);
        chk("rst_prod", prod_v, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        reset_n = 1'b1;

        mul(0, 16'd13, 16'd11, 32'd143, "m13x11");
        mul(0, 16'd255, 16'd255, 32'hFE01, "m255x255");
        mul(0, 16'd0, 16'd200, 32'd0, "m0x200");

        // St held high for 60 cycles: accepts at edges 0, 18, 36, 54.
        sel = 0;
        @(negedge Clk);
        mc = 16'd3; mp = 16'd7; st8 = 1'b1;
        for (int k = 0; k < 4; k++) sb.push_back(32'd21);
        nd = 0; last = 0;
        for (int i = 1; i <= 90; i++) begin
            @(negedge Clk);
            if (i == 60) st8 = 1'b0;
            if (done_v) begin
                if (nd == 0) chk("b2b_first", 32'(i), 32'd17);
                else         chk("b2b_gap", 32'(i - last), 32'd18);
                chk("b2b_prod", prod_v, pop_exp());
                last = i;
                nd++;
            end
        end
        chk("b2b_count", 32'(nd), 32'd4);

        // St and operands toggling while Busy must not restart or retime the operation.
        @(negedge Clk);
        mc = 16'd3; mp = 16'd7; st8 = 1'b1;
        sb.push_back(32'd21);
        nd = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if (i <= 14) begin
                st8 = ~st8;
                mc = mc + 16'd1;
                mp = mp + 16'd3;
            end else begin
                st8 = 1'b0;
            end
            if (done_v) begin
                if (nd == 0) chk("tgl_latency", 32'(i), 32'd17);
                chk("tgl_prod", prod_v, pop_exp());
                nd++;
            end
        end
        chk("tgl_count", 32'(nd), 32'd1);

        // Asynchronous reset in the middle of 5x9.
        @(negedge Clk);
        mc = 16'd5; mp = 16'd9; st8 = 1'b1;
        @(negedge Clk);
        st8 = 1'b0;
        repeat (4) @(negedge Clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_prod", prod_v, 32'd0);
        chk("abort_idle", 32'(idle_v), 32'd1);
        chk("abort_busy", 32'(busy_v), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        reset_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (done_v) nd++;
        end
        chk("abort_nodone", 32'(nd), 32'd0);
        mul(0, 16'd5, 16'd9, 32'd45, "m5x9");

        mul(1, 16'd15, 16'd15, 32'd225, "w4_15x15");
        mul(2, 16'hFFFF, 16'h0002, 32'h0001FFFE, "w16_ffffx2");

`ifdef MULT_SIGNED_EN
        sgn = 1'b1;
        mul(0, 16'h00FD, 16'h0005, 32'hFFF1, "s_m3x5");
        mul(0, 16'h0080, 16'h0080, 32'h4000, "s_m128xm128");
        mul(0, 16'h00FF, 16'h007F, 32'hFF81, "s_m1x127");
        sgn = 1'b0;
        mul(0, 16'h00FD, 16'h0005, 32'h04F1, "u_fdx5");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
